// File: rtl/wb_target_mem_pkg.sv
// Shared definitions for the Wishbone target memory: FSM state encodings,
// counter width and a small address helper.
package wb_target_mem_pkg;

    // FSM state encodings
    localparam logic [1:0] LP_ST_IDLE = 2'd0;
    localparam logic [1:0] LP_ST_WAIT = 2'd1;
    localparam logic [1:0] LP_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = LP_ST_IDLE,
        ST_WAIT = LP_ST_WAIT,
        ST_RESP = LP_ST_RESP
    } state_t;

    // Wait-state counter covers 0..15
    localparam int LP_CNT_WIDTH = 4;

    // Number of byte-address bits below the word index
    function automatic int byte_offset_bits(input int dat_width);
        return $clog2(dat_width / 8);
    endfunction

endpackage

// File: rtl/wb_target_mem_ram.sv
// Single-port byte-enabled storage with synchronous, enable-gated read.
// The read register only changes when i_re is high, so it holds the last
// word read for as long as the owner needs it.
module wb_target_mem_ram #(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int AW        = 10
) (
    input  logic                   clock,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic [DAT_WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]          i_addr,
    input  logic [DAT_WIDTH-1:0]   i_wdata,
    output logic [DAT_WIDTH-1:0]   o_rdata
);

    localparam int LP_NB = DAT_WIDTH / 8;

    logic [DAT_WIDTH-1:0] r_mem [DEPTH];
    logic [DAT_WIDTH-1:0] r_q;

    // Per-byte write and registered read of the addressed word
    // NOTE: the array has no reset; clearing it would turn block RAM into flops.
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < LP_NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/wb_target_mem.sv
// Classic (non-pipelined) Wishbone responder backed by byte-enabled RAM.
// A sampled strobe is answered with exactly one ack or err cycle after
// WAIT_STATES extra cycles; out-of-range word indices get err.
module wb_target_mem
    import wb_target_mem_pkg::*;
#(
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   t_adr,
    input  logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic                   t_cyc,
    input  logic                   t_stb,
    input  logic [DAT_WIDTH/8-1:0] t_sel,
    input  logic                   t_we,
    output logic                   t_ack,
    output logic                   t_err
);

    localparam int LP_SEL_W = DAT_WIDTH / 8;
    localparam int LP_OFF   = byte_offset_bits(DAT_WIDTH);
    localparam int LP_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADR_WIDTH:0]      LP_WORDS_EXT = (ADR_WIDTH + 1)'(MEM_WORDS);
    localparam logic [LP_CNT_WIDTH-1:0] LP_WAIT      = LP_CNT_WIDTH'(WAIT_STATES);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LP_CNT_WIDTH-1:0] r_cnt;
    logic [LP_CNT_WIDTH-1:0] w_cnt_next;
    logic                    r_ack;
    logic                    r_err;
    logic                    w_ack_next;
    logic                    w_err_next;
    logic                    r_rd_valid;

    logic [ADR_WIDTH-1:0]    r_adr;
    logic [DAT_WIDTH-1:0]    r_dat_w;
    logic [LP_SEL_W-1:0]     r_sel;
    logic                    r_we;

    logic                    w_req;
    logic                    w_latch;
    logic                    w_enter_resp;
    logic                    w_ram_re;
    logic                    w_ram_we;
    logic [ADR_WIDTH-1:0]    w_adr_cur;
    logic                    w_we_cur;
    logic [ADR_WIDTH-1:0]    w_index;
    logic                    w_in_range;
    logic [DAT_WIDTH-1:0]    w_ram_q;

    assign w_req = t_cyc && t_stb;

    // In IDLE the live bus is decoded so a zero-wait read can be issued on
    // the accepting edge; afterwards the latched request is used.
    assign w_adr_cur  = (r_state == ST_IDLE) ? t_adr : r_adr;
    assign w_we_cur   = (r_state == ST_IDLE) ? t_we  : r_we;
    assign w_index    = w_adr_cur >> LP_OFF;
    assign w_in_range = ({1'b0, w_index} < LP_WORDS_EXT);

    // Next-state, wait counter and response decode
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = LP_WAIT;
                    end else begin
                        w_state_next = ST_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!t_cyc) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_ack_next = w_enter_resp && w_in_range;
        w_err_next = w_enter_resp && !w_in_range;
        // Read lands in the RAM register on the edge entering RESP
        w_ram_re   = w_enter_resp && !w_we_cur && w_in_range && !reset;
        // Write commits on the edge that ends RESP
        w_ram_we   = (r_state == ST_RESP) && r_we && w_in_range && !reset;
    end

    // State, counter and registered terminations
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            if (w_ram_re) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    // Capture the request; only meaningful while a transaction is live
    always_ff @(posedge clock) begin
        if (w_latch) begin
            r_adr   <= t_adr;
            r_dat_w <= t_dat_w;
            r_sel   <= t_sel;
            r_we    <= t_we;
        end
    end

    wb_target_mem_ram #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (MEM_WORDS),
        .AW        (LP_AW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_be    (r_sel),
        .i_addr  (w_index[LP_AW-1:0]),
        .i_wdata (r_dat_w),
        .o_rdata (w_ram_q)
    );

    // The RAM register is not reset, so read data is masked until the
    // first read after reset has loaded it.
    assign t_dat_r = r_rd_valid ? w_ram_q : '0;
    assign t_ack   = r_ack;
    assign t_err   = r_err;

endmodule

// File: doc/wb_target_mem.md
WB_TARGET_MEM -- requirements
Module: wb_target_mem

Interface
REQ-001 Parameter ADR_WIDTH, default 32, width of the Wishbone byte address.
REQ-002 Parameter DAT_WIDTH, default 32, data width; SHALL be 8, 16, 32 or 64.
REQ-003 Parameter MEM_WORDS, default 1024, storage depth in DAT_WIDTH words; SHALL be a power of two.
REQ-004 Parameter WAIT_STATES, default 0, range 0..15, extra cycles inserted before the ack.
REQ-005 Port clock  in  1  sole clock; all logic is rising-edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port t_adr  in  ADR_WIDTH  byte address.
REQ-008 Port t_dat_w  in  DAT_WIDTH  write data.
REQ-009 Port t_dat_r  out  DAT_WIDTH  read data.
REQ-010 Port t_cyc  in  1  bus cycle.
REQ-011 Port t_stb  in  1  strobe.
REQ-012 Port t_sel  in  DAT_WIDTH/8  byte selects.
REQ-013 Port t_we  in  1  write enable.
REQ-014 Port t_ack  out  1  normal termination.
REQ-015 Port t_err  out  1  error termination.

Function
REQ-016 The block SHALL act as a classic (non-pipelined) Wishbone responder, terminating the initiator side of the bus bridge.
REQ-017 Word index SHALL be t_adr >> log2(DAT_WIDTH/8); an index of MEM_WORDS or greater is out of range.
REQ-018 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-019 In IDLE with t_cyc&t_stb sampled high, the block SHALL latch adr/dat_w/sel/we, then go to WAIT (counter=WAIT_STATES) if WAIT_STATES>0, else to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; on reaching 1 the FSM SHALL go to RESP.
REQ-021 In RESP, exactly one of t_ack or t_err SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be exactly WAIT_STATES+1 cycles from the sampled strobe to ack/err.
REQ-023 A write SHALL update only the bytes whose latched sel bit is 1, on the clock edge that ends RESP.
REQ-024 A read SHALL present the word on t_dat_r in the RESP cycle; t_dat_r SHALL hold that value until the next read's RESP.
REQ-025 An out-of-range access SHALL assert t_err instead of t_ack, perform no write, and leave t_dat_r unchanged.
REQ-026 A read or write with all sel bits 0 SHALL be acked; a write with all sel bits 0 SHALL modify nothing.
REQ-027 If t_cyc drops in WAIT, the FSM SHALL abort to IDLE with no ack, no err and no write.
REQ-028 A strobe still high in the cycle after RESP SHALL be treated as a new transaction, giving back-to-back ack every WAIT_STATES+2 cycles.
REQ-029 t_ack and t_err SHALL be registered outputs and never high together.

Reset
REQ-030 Reset SHALL force the FSM to IDLE, the wait counter to 0, t_ack=0, t_err=0 and t_dat_r=0.
REQ-031 Reset asserted mid-transaction SHALL cancel it with no ack and no write; memory contents SHALL NOT be cleared.
REQ-032 A strobe present in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-033 The FSM state encodings (IDLE=0, WAIT=1, RESP=2) SHALL be localparams in the shared wishbone package, alongside the existing port macros.
REQ-034 The byte-enabled storage SHALL be one sub-module, wb_target_mem_ram (single port, synchronous read, per-byte write enable, no reset).

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> ack 1 cycle after each strobe, read data 0xDEADBEEF.
REQ-036 Write 0x11223344 to 0x20 with sel=0xF, then 0xAABBCCDD with sel=0x5, then read 0x20 -> 0x11BB33DD.
REQ-037 WAIT_STATES=3: read -> ack exactly 4 cycles after the strobe is sampled, for exactly 1 cycle.
REQ-038 MEM_WORDS=1024, DAT_WIDTH=32: write to 0x1000 -> t_err for 1 cycle, no ack, word 0 unchanged.
REQ-039 WAIT_STATES=3: drop t_cyc 1 cycle after the strobe -> no ack/err, write suppressed; next transaction completes normally.
REQ-040 Assert reset during WAIT of a write to 0x4 -> outputs 0, no ack, old contents of 0x4 read back after reset.
